// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state encodings for the lab ALU and its scheduler.
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_core.sv
// Purely combinational W-bit lab ALU: add/sub with carry and signed overflow,
// bitwise ops, signed less-than and equality.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] f,
    output logic         zero,
    output logic         over,
    output logic         cout
);
    logic [W:0]   add_s;
    logic [W:0]   sub_s;
    logic [W-1:0] nb;
    logic         add_ov;
    logic         sub_ov;
    logic         less;

    assign nb     = ~b;
    assign add_s  = {1'b0, a} + {1'b0, b};
    assign sub_s  = {1'b0, a} + {1'b0, nb} + {{W{1'b0}}, 1'b1};
    assign add_ov = (a[W-1] == b[W-1])  && (add_s[W-1] != a[W-1]);
    assign sub_ov = (a[W-1] == nb[W-1]) && (sub_s[W-1] != a[W-1]);
    // Signed compare reuses the subtract path: sign of a-b corrected by overflow.
    assign less   = sub_s[W-1] ^ sub_ov;

    always_comb begin
        f    = '0;
        over = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin f = add_s[W-1:0]; over = add_ov; cout = add_s[W]; end
            OP_SUB: begin f = sub_s[W-1:0]; over = sub_ov; cout = sub_s[W]; end
            OP_NOT: f = ~a;
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_XOR: f = a ^ b;
            OP_LT:  f = {{(W-1){1'b0}}, less};
            OP_EQ:  f = {{(W-1){1'b0}}, (a == b)};
            default: f = '0;
        endcase
    end

    assign zero = (f == '0);
endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one alu_core between two requesters, with a
// single-entry response register. Define ALU_SCHED_STATS_EN for grant counters.
module alu_sched
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_f,
    output logic         rsp_zero,
    output logic         rsp_over,
    output logic         rsp_cout
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);
    state_t       state, state_nx;
    logic         last;
    logic         grant;
    logic         any;
    logic         accept;
    logic [W-1:0] a_q, b_q;
    logic [2:0]   op_q;
    logic         id_q;
    logic [W-1:0] f_c;
    logic         zero_c, over_c, cout_c;

    assign any    = req0_valid | req1_valid;
    // On a tie the requester not served last wins; otherwise the lone valid one.
    assign grant  = (req0_valid && req1_valid) ? ~last : req1_valid;
    assign accept = (state == S_IDLE) && any;

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req0_ready = any && !grant;
                req1_ready = any && grant;
                if (any) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            last  <= 1'b1;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q  <= grant ? req1_a  : req0_a;
                b_q  <= grant ? req1_b  : req0_b;
                op_q <= grant ? req1_op : req0_op;
                id_q <= grant;
                last <= grant;
            end
        end
    end

    alu_core #(.W(W)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .f    (f_c),
        .zero (zero_c),
        .over (over_c),
        .cout (cout_c)
    );

    // Result register only loads at the end of EXEC, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_f    <= '0;
            rsp_zero <= 1'b0;
            rsp_over <= 1'b0;
            rsp_cout <= 1'b0;
            rsp_id   <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_f    <= f_c;
            rsp_zero <= zero_c;
            rsp_over <= over_c;
            rsp_cout <= cout_c;
            rsp_id   <= id_q;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (accept) begin
            if (grant) grant_cnt1 <= grant_cnt1 + 16'd1;
            else       grant_cnt0 <= grant_cnt0 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: expected responses are queued at accept time
// and compared when the response handshake happens.
module tb_alu_sched;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [2:0]   req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_f;
    logic         rsp_zero, rsp_over, rsp_cout;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1;
`endif

    alu_sched #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_f      (rsp_f),
        .rsp_zero   (rsp_zero),
        .rsp_over   (rsp_over),
        .rsp_cout   (rsp_cout)
`ifdef ALU_SCHED_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [3:0] f;
        logic       zero;
        logic       over;
        logic       cout;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   acc0 = 0;
    int   acc1 = 0;

    // Reference ALU in integer arithmetic, independent of the bit-level RTL.
    function automatic exp_t model(input logic id, input logic [3:0] a, input logic [3:0] b,
                                   input logic [2:0] op);
        exp_t e;
        int ua, ub, sa, sbv, s, r;
        ua = int'(a);
        ub = int'(b);
        sa  = a[3] ? ua - 16 : ua;
        sbv = b[3] ? ub - 16 : ub;
        e.id = id; e.f = 4'd0; e.over = 1'b0; e.cout = 1'b0;
        case (op)
            3'd0: begin s = ua + ub; e.f = 4'(s); e.cout = (s > 15);
                        r = sa + sbv; e.over = (r > 7) || (r < -8); end
            3'd1: begin s = ua + (15 - ub) + 1; e.f = 4'(s); e.cout = (s > 15);
                        r = sa - sbv; e.over = (r > 7) || (r < -8); end
            3'd2: e.f = 4'(15 - ua);
            3'd3: e.f = a & b;
            3'd4: e.f = a | b;
            3'd5: e.f = a ^ b;
            3'd6: e.f = (sa < sbv) ? 4'd1 : 4'd0;
            default: e.f = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        e.zero = (e.f == 4'd0);
        return e;
    endfunction

    task automatic do_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
        logic got;
        got = 1'b0;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        total++;
        if (got !== 1'b1) begin
            bad++;
            $display("FAIL req_accept: id=%0d ready got=%b need=1", id, got);
        end else begin
            sb.push_back(model(id, a, b, op));
            if (id) acc1++; else acc0++;
        end
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    // Scoreboard pop: waits for rsp_valid (rsp_ready already 1), compares, consumes.
    task automatic pop_rsp();
        int   n;
        exp_t e;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        total++;
        if (!rsp_valid) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid got=0 need=1");
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d f=%h, queue empty", rsp_id, rsp_f);
        end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout} !== {e.id, e.f, e.zero, e.over, e.cout}) begin
                bad++;
                $display("FAIL rsp_data: got id=%0d f=%h z=%b v=%b c=%b need id=%0d f=%h z=%b v=%b c=%b",
                         rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, e.id, e.f, e.zero, e.over, e.cout);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, req0_ready, req1_ready} !== '0) begin
            bad++;
            $display("FAIL reset_state: got v=%b id=%b f=%h z=%b o=%b c=%b r0=%b r1=%b need all 0",
                     rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, req0_ready, req1_ready);
        end
`ifdef ALU_SCHED_STATS_EN
        total++;
        if ({grant_cnt0, grant_cnt1} !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d/%0d need 0/0", grant_cnt0, grant_cnt1);
        end
`endif
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        rsp_ready = 1;
        do_req(0, 4'b0111, 4'b0001, 3'b000);
        @(negedge clk);
        total++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            bad++;
            $display("FAIL add_exec: got v=%b r0=%b r1=%b need 000", rsp_valid, req0_ready, req1_ready);
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_f, rsp_over, rsp_cout, rsp_zero, rsp_id} !== {1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL add_rsp: got v=%b f=%b o=%b c=%b z=%b id=%b need v=1 f=1000 o=1 c=0 z=0 id=0",
                     rsp_valid, rsp_f, rsp_over, rsp_cout, rsp_zero, rsp_id);
        end
        pop_rsp();
    endtask

    task automatic test_sub_cmp();
        do_req(1, 4'b0011, 4'b0011, 3'b001);
        repeat (2) @(negedge clk);
        total++;
        if ({rsp_f, rsp_zero, rsp_cout, rsp_over, rsp_id} !== {4'b0000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sub_rsp: got f=%b z=%b c=%b o=%b id=%b need f=0000 z=1 c=1 o=0 id=1",
                     rsp_f, rsp_zero, rsp_cout, rsp_over, rsp_id);
        end
        pop_rsp();
        do_req(1, 4'b1000, 4'b0001, 3'b110);
        repeat (2) @(negedge clk);
        total++;
        if (rsp_f !== 4'b0001) begin
            bad++;
            $display("FAIL lt_rsp: got f=%b need 0001", rsp_f);
        end
        pop_rsp();
    endtask

    task automatic test_fair();
        logic exp_g;
        logic got;
        req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'b000;
        req1_valid = 1; req1_a = 4'd4; req1_b = 4'd3; req1_op = 3'b001;
        for (int k = 0; k < 6; k++) begin
            exp_g = k[0];
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = req0_ready | req1_ready;
            end
            total++;
            if ({req0_ready, req1_ready} !== (exp_g ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL fair_grant%0d: got r0=%b r1=%b need grant=%0d", k, req0_ready, req1_ready, exp_g);
            end
            if (exp_g) begin sb.push_back(model(1, req1_a, req1_b, req1_op)); acc1++; end
            else       begin sb.push_back(model(0, req0_a, req0_b, req0_op)); acc0++; end
            @(posedge clk); #1;
            if (exp_g) req1_a = req1_a + 4'd5; else req0_a = req0_a + 4'd3;
            @(negedge clk);
            total++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                bad++;
                $display("FAIL fair_busy%0d: got r0=%b r1=%b need 00", k, req0_ready, req1_ready);
            end
            pop_rsp();
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        rsp_ready = 0;
        do_req(0, 4'd2, 4'd3, 3'b000);
        repeat (2) @(negedge clk);
        req1_valid = 1; req1_a = 4'd9; req1_b = 4'd9; req1_op = 3'b111;
        held = {rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout};
        total++;
        if (held !== {1'b0, 4'd5, 3'b000}) begin
            bad++;
            $display("FAIL bp_value: got %b need %b", held, {1'b0, 4'd5, 3'b000});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout, req0_ready, req1_ready} !== {1'b1, held, 2'b00}) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%b rsp=%b r0=%b r1=%b need v=1 rsp=%b r=00",
                         i, rsp_valid, {rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout}, req0_ready, req1_ready, held);
            end
        end
        rsp_ready = 1;
        pop_rsp();
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: req1_ready got=%b need=1", req1_ready);
        end
        sb.push_back(model(1, 4'd9, 4'd9, 3'b111));
        acc1++;
        @(posedge clk); #1;
        req1_valid = 0;
        pop_rsp();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1;
        do_req(0, 4'd5, 4'd6, 3'b000);
        #2 rst = 1;
        #1;
        total++;
        if ({rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b id=%b f=%h z=%b o=%b c=%b need all 0",
                     rsp_valid, rsp_id, rsp_f, rsp_zero, rsp_over, rsp_cout);
        end
        sb.delete();
        acc0 = 0; acc1 = 0;
        @(posedge clk); #1;
        rst = 0;
        req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'b011;
        req1_valid = 1; req1_a = 4'd2; req1_b = 4'd2; req1_op = 3'b100;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL mid_tie: got r0=%b r1=%b need 10", req0_ready, req1_ready);
        end
        sb.push_back(model(0, 4'd1, 4'd1, 3'b011));
        acc0++;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        pop_rsp();
    endtask

    task automatic test_logic();
        logic [3:0] ta[7];
        logic [3:0] tb[7];
        logic [2:0] to[7];
        logic [3:0] tf[7];
        ta = '{4'hC, 4'hC, 4'hC, 4'hC, 4'hC, 4'hF, 4'h0};
        tb = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'h1, 4'h1};
        to = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd1};
        tf = '{4'h3, 4'h8, 4'hE, 4'h6, 4'h0, 4'h0, 4'hF};
        for (int i = 0; i < 7; i++) begin
            do_req(i[0], ta[i], tb[i], to[i]);
            repeat (2) @(negedge clk);
            total++;
            if (rsp_f !== tf[i]) begin
                bad++;
                $display("FAIL logic%0d: op=%b f got=%b need=%b", i, to[i], rsp_f, tf[i]);
            end
            pop_rsp();
        end
    endtask

    task automatic test_stats();
`ifdef ALU_SCHED_STATS_EN
        total++;
        if (grant_cnt0 !== 16'(acc0) || grant_cnt1 !== 16'(acc1)) begin
            bad++;
            $display("FAIL stats: got %0d/%0d need %0d/%0d", grant_cnt0, grant_cnt1, acc0, acc1);
        end
`endif
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d responses outstanding, need 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_fair();
        test_backpressure();
        test_reset_mid();
        test_logic();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Shares one W-bit ALU (the lab ALU op set) between two requesters.
- Each requester uses a valid/ready request handshake; arbitration is round-robin.
- Operands and opcode are latched, executed in one cycle, and the result plus flags are held in a single-entry response register with a valid/ready handshake.
- Sits between the two operand sources (e.g. a keypad/switch front end and a test sequencer) and the display/result consumer.

Parameters:
- W, 4, operand/result width in bits; all ALU arithmetic is W bits wide.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  W  operand a.
- req0_b  input  W  operand b.
- req0_op  input  3  ALU opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same directions, widths and meanings as the requester 0 ports, for requester 1.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  index of the requester that issued the result.
- rsp_f  output  W  ALU result.
- rsp_zero  output  1  zero flag.
- rsp_over  output  1  signed overflow flag.
- rsp_cout  output  1  carry/borrow-out flag.

Behaviour:
- Opcode encoding (a, b two's complement):
  - 000: a+b. cout = carry out. over = (a[W-1]==b[W-1]) && (f[W-1]!=a[W-1]).
  - 001: a-b, computed as a + ~b + 1. cout = carry of that sum. over uses ~b in place of b.
  - 010: f = ~a.
  - 011: f = a&b.
  - 100: f = a|b.
  - 101: f = a^b.
  - 110: f = {0..0, signed a<b}; less is computed from the subtract path as sign XOR over.
  - 111: f = {0..0, a==b}.
- zero = (f==0) for every opcode. over and cout are 0 for every opcode except 000 and 001.
- FSM states:
  - IDLE:
    - req0_ready = (grant==0), req1_ready = (grant==1); both 0 when neither requester is valid.
    - An accepted handshake latches a, b, op and id into op registers, updates the round-robin pointer to the granted index, and moves to EXEC.
  - EXEC:
    - Both readys are 0.
    - The ALU computes from the op registers; rsp_f, flags and rsp_id are registered at the clock edge ending EXEC; next state is RESP.
  - RESP:
    - rsp_valid = 1; both readys are 0.
    - rsp_valid=1 && rsp_ready=1 at an edge moves to IDLE.
    - rsp_f, flags and rsp_id stay stable while rsp_ready=0 (indefinite backpressure).
- Arbitration:
  - Only one requester valid: grant goes to it.
  - Both valid: grant goes to the requester not granted last.
  - The pointer resets to "last=1", so requester 0 wins the first tie.
  - Readys are combinational from valids and state; valids are not required to stay high without a handshake.
- Latency:
  - A request accepted at edge N gives rsp_valid=1 in the cycle after edge N+1.
  - Throughput is at most one operation per 3 cycles when rsp_ready is tied high.
- Reset:
  - Asynchronous assertion at any time, including mid-EXEC or mid-RESP: state=IDLE, rsp_valid=0, rsp_f=0, rsp_zero=0, rsp_over=0, rsp_cout=0, rsp_id=0, op registers=0, pointer=1.
  - An in-flight operation is discarded.
- Wrap-around: arithmetic is modulo 2^W; cout and over report it; no saturation.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- ALU_SCHED_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each.
  - Each counter increments by 1 per accepted handshake of its requester and wraps 0xFFFF→0.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD..OP_EQ (3 bits).
  - FSM state encodings S_IDLE/S_EXEC/S_RESP (2 bits).
- One sub-module, alu_core:
  - Purely combinational W-bit ALU.
  - Inputs a, b, op; outputs f, zero, over, cout.
  - Implements the opcode table above.
  - Instantiated once inside alu_sched; reusable by other labs.

Test Plan:
- Single add, W=4: req0 a=0111 b=0001 op=000, rsp_ready=1 → rsp_valid 2 cycles after accept; f=1000, over=1, cout=0, zero=0, id=0.
- Subtract and compare:
  - req1 a=0011 b=0011 op=001 → f=0000, zero=1, cout=1, over=0, id=1.
  - Then a=1000 b=0001 op=110 → f=0001 (−8<1).
- Fairness: both valid continuously with distinct operands → grants alternate 0,1,0,1…; rsp_id sequence matches; first grant is 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req*_ready=0 throughout; rsp_ready=1 → IDLE next cycle, next request accepted.
- Reset mid-operation: assert rst during EXEC → rsp_valid=0, all outputs 0 immediately (async); after release, the first tie goes to requester 0.
- Logic ops plus stats: a=1100 b=1010 with op 010/011/100/101/111 → 0011/1000/1110/0110/0000 (zero=1 for 111). With ALU_SCHED_STATS_EN, grant counts equal the number of accepts per requester.
